// File: rtl/fetch_instr_queue.sv
// rtl/fetch_instr_queue.sv - fetch-to-decode instruction queue with lane compaction
module fetch_instr_queue #(
  parameter int IN_LANES    = 2,
  parameter int OUT_LANES   = 2,
  parameter int DEPTH       = 8,
  parameter int PACKET_SIZE = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush_i,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic [IN_LANES*PACKET_SIZE-1:0]  in_data_i,
  input  logic [IN_LANES-1:0]              in_lane_valid_i,
  input  logic [IN_LANES-1:0]              in_taken_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [OUT_LANES*PACKET_SIZE-1:0] out_data_o,
  output logic [OUT_LANES-1:0]             out_lane_valid_o,
  output logic [$clog2(DEPTH+1)-1:0]       count_o
);

  localparam int PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW       = $clog2(DEPTH + 1);
  localparam int KW       = $clog2(OUT_LANES + 1);
  localparam int LOAD_MAX = (OUT_LANES < DEPTH) ? OUT_LANES : DEPTH;

  logic [PACKET_SIZE-1:0]           r_mem [DEPTH];
  logic [PW-1:0]                    r_head;
  logic [PW-1:0]                    r_tail;
  logic [CW-1:0]                    r_count;
  logic [OUT_LANES*PACKET_SIZE-1:0] r_stage_data;
  logic [KW-1:0]                    r_stage_k;
  logic                             r_stage_valid;

  logic [IN_LANES-1:0]              w_keep;
  logic [PW-1:0]                    w_wr_idx [IN_LANES];
  logic [CW-1:0]                    w_kept_cnt;
  logic                             w_blocked;
  logic                             w_push;
  logic                             w_stage_free;
  logic                             w_load;
  logic [CW-1:0]                    w_load_k;
  logic [CW-1:0]                    w_push_cnt;
  logic [CW-1:0]                    w_pop_cnt;
  logic [OUT_LANES*PACKET_SIZE-1:0] w_stage_data_nxt;

  // Readiness uses registered occupancy only, so a full group always fits.
  assign in_ready_o   = !flush_i && (r_count <= CW'(DEPTH - IN_LANES));
  assign w_push       = in_valid_i && in_ready_o;
  assign out_valid_o  = r_stage_valid && !flush_i;
  assign w_stage_free = !r_stage_valid || (out_valid_o && out_ready_i);
  assign w_load_k     = (r_count > CW'(LOAD_MAX)) ? CW'(LOAD_MAX) : r_count;
  assign w_load       = w_stage_free && (r_count != '0);
  assign w_push_cnt   = w_push ? w_kept_cnt : '0;
  assign w_pop_cnt    = w_load ? w_load_k : '0;
  assign out_data_o   = r_stage_data;
  assign count_o      = r_count;

  // Keep valid lanes up to and including the first predicted-taken one, and pack them at tail.
  always_comb begin
    w_blocked  = 1'b0;
    w_kept_cnt = '0;
    w_keep     = '0;
    for (int i = 0; i < IN_LANES; i++) begin
      w_keep[i]   = in_lane_valid_i[i] && !w_blocked;
      w_wr_idx[i] = r_tail + w_kept_cnt[PW-1:0];
      if (w_keep[i]) begin
        w_kept_cnt = w_kept_cnt + CW'(1);
      end
      if (in_lane_valid_i[i] && in_taken_i[i]) begin
        w_blocked = 1'b1;
      end
    end
  end

  // Gather the next output group from head; lanes beyond the load count stay zero.
  always_comb begin
    w_stage_data_nxt = '0;
    for (int j = 0; j < OUT_LANES; j++) begin
      if (j < int'(w_load_k)) begin
        w_stage_data_nxt[j*PACKET_SIZE +: PACKET_SIZE] = r_mem[r_head + PW'(j)];
      end
    end
  end

  // Thermometer mask of occupied output lanes.
  always_comb begin
    out_lane_valid_o = '0;
    for (int j = 0; j < OUT_LANES; j++) begin
      out_lane_valid_o[j] = (j < int'(r_stage_k));
    end
  end

  // Packet storage; written only for kept lanes of an accepted group.
  always_ff @(posedge clk) begin
    if (w_push) begin
      for (int i = 0; i < IN_LANES; i++) begin
        if (w_keep[i]) begin
          r_mem[w_wr_idx[i]] <= in_data_i[i*PACKET_SIZE +: PACKET_SIZE];
        end
      end
    end
  end

  // Pointers, occupancy and output stage; flush overrides any push or load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_stage_data  <= '0;
      r_stage_k     <= '0;
      r_stage_valid <= 1'b0;
    end else if (flush_i) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_stage_data  <= '0;
      r_stage_k     <= '0;
      r_stage_valid <= 1'b0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + w_kept_cnt[PW-1:0];
      end
      r_count <= r_count + w_push_cnt - w_pop_cnt;
      if (w_stage_free) begin
        if (w_load) begin
          r_head        <= r_head + w_load_k[PW-1:0];
          r_stage_data  <= w_stage_data_nxt;
          r_stage_k     <= KW'(w_load_k);
          r_stage_valid <= 1'b1;
        end else begin
          r_stage_data  <= '0;
          r_stage_k     <= '0;
          r_stage_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_instr_queue.sv
// tb/tb_fetch_instr_queue.sv - self-checking bench for fetch_instr_queue
module tb_fetch_instr_queue;
  localparam int IL = 2;
  localparam int OL = 2;
  localparam int D  = 8;
  localparam int PS = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [IL*PS-1:0] in_data_i;
  logic [IL-1:0]   in_lane_valid_i;
  logic [IL-1:0]   in_taken_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [OL*PS-1:0] out_data_o;
  logic [OL-1:0]   out_lane_valid_o;
  logic [3:0]      count_o;

  int checks = 0;
  int errors = 0;
  int n_acc  = 0;

  logic [63:0] m_fifo [$];
  logic [63:0] m_stage [$];
  logic        m_sv = 1'b0;
  logic [63:0] last_a;
  logic [63:0] last_b;

  typedef struct {
    logic [1:0] lv;
    logic [1:0] tk;
    int         kept;
    logic [1:0] mask;
    int         src;
  } vec_t;
  vec_t vt [8];

  fetch_instr_queue #(.IN_LANES(IL), .OUT_LANES(OL), .DEPTH(D), .PACKET_SIZE(PS)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_data_i(in_data_i), .in_lane_valid_i(in_lane_valid_i), .in_taken_i(in_taken_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_lane_valid_o(out_lane_valid_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs(input logic ordy);
    in_valid_i      = 1'b0;
    in_lane_valid_i = '0;
    in_taken_i      = '0;
    flush_i         = 1'b0;
    out_ready_i     = ordy;
    #1;
  endtask

  // One clock: drive at negedge, compare against the queue model, advance the model.
  task automatic cycle(input logic iv, input logic [1:0] lv, input logic [1:0] tk,
                       input logic ordy, input logic fl);
    logic [63:0]  a;
    logic [63:0]  b;
    logic         exp_ready;
    logic [1:0]   exp_lv;
    logic [127:0] exp_data;
    logic         blocked;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    in_valid_i = iv; in_lane_valid_i = lv; in_taken_i = tk;
    in_data_i = {b, a}; out_ready_i = ordy; flush_i = fl;
    #1;
    exp_ready = !fl && ((D - m_fifo.size()) >= IL);
    chk("in_ready", 128'(in_ready_o), 128'(exp_ready));
    chk("out_valid", 128'(out_valid_o), 128'(m_sv && !fl));
    chk("count", 128'(count_o), 128'(m_fifo.size()));
    exp_lv = '0;
    exp_data = '0;
    for (int j = 0; j < m_stage.size(); j++) begin
      exp_lv[j] = 1'b1;
      exp_data[j*64 +: 64] = m_stage[j];
    end
    chk("out_lane_valid", 128'(out_lane_valid_o), 128'(exp_lv));
    chk("out_data", out_data_o, exp_data);
    if (iv && in_ready_o) n_acc++;
    if (fl) begin
      m_fifo.delete(); m_stage.delete(); m_sv = 1'b0;
    end else begin
      if (!m_sv || ordy) begin
        m_stage.delete();
        m_sv = 1'b0;
        while (m_fifo.size() > 0 && m_stage.size() < OL) begin
          m_stage.push_back(m_fifo.pop_front());
          m_sv = 1'b1;
        end
      end
      if (iv && exp_ready) begin
        blocked = 1'b0;
        if (lv[0]) begin
          m_fifo.push_back(a);
          if (tk[0]) blocked = 1'b1;
        end
        if (lv[1] && !blocked) m_fifo.push_back(b);
      end
    end
    last_a = a;
    last_b = b;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int n = 0; n < 12; n++) cycle(1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] exp0;
    vt[0] = '{2'b11, 2'b00, 2, 2'b11, 0};
    vt[1] = '{2'b11, 2'b01, 1, 2'b01, 0};
    vt[2] = '{2'b10, 2'b00, 1, 2'b01, 1};
    vt[3] = '{2'b01, 2'b00, 1, 2'b01, 0};
    vt[4] = '{2'b00, 2'b00, 0, 2'b00, 0};
    vt[5] = '{2'b11, 2'b10, 2, 2'b11, 0};
    vt[6] = '{2'b10, 2'b01, 1, 2'b01, 1};
    vt[7] = '{2'b01, 2'b11, 1, 2'b01, 0};

    rst = 1'b1;
    in_data_i = '0;
    idle_inputs(1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs(1'b1);
    chk("rst_out_valid", 128'(out_valid_o), 128'(0));
    chk("rst_count", 128'(count_o), 128'(0));
    chk("rst_in_ready", 128'(in_ready_o), 128'(1));

    // Lane selection vectors, each pushed into an empty queue.
    for (int v = 0; v < 8; v++) begin
      cycle(1'b1, vt[v].lv, vt[v].tk, 1'b1, 1'b0);
      exp0 = (vt[v].src == 1) ? last_b : last_a;
      idle_inputs(1'b1);
      chk("tbl_count", 128'(count_o), 128'(vt[v].kept));
      cycle(1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
      idle_inputs(1'b1);
      chk("tbl_mask", 128'(out_lane_valid_o), 128'(vt[v].mask));
      if (vt[v].kept > 0) chk("tbl_lane0", 128'(out_data_o[63:0]), 128'(exp0));
      drain();
    end

    // Fill under backpressure, then release and drain in order across the wrap.
    n_acc = 0;
    for (int n = 0; n < 7; n++) cycle(1'b1, 2'b11, 2'b00, 1'b0, 1'b0);
    chk("fill_groups", 128'(n_acc), 128'(5));
    idle_inputs(1'b0);
    chk("fill_count", 128'(count_o), 128'(8));
    chk("fill_not_ready", 128'(in_ready_o), 128'(0));
    drain();

    // Odd occupancy drains as 2 then 1.
    cycle(1'b1, 2'b11, 2'b00, 1'b0, 1'b0);
    cycle(1'b1, 2'b11, 2'b00, 1'b0, 1'b0);
    cycle(1'b1, 2'b01, 2'b00, 1'b0, 1'b0);
    idle_inputs(1'b1);
    chk("odd_count3", 128'(count_o), 128'(3));
    cycle(1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
    idle_inputs(1'b1);
    chk("odd_count1", 128'(count_o), 128'(1));
    chk("odd_mask11", 128'(out_lane_valid_o), 128'(2'b11));
    cycle(1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
    idle_inputs(1'b1);
    chk("odd_count0", 128'(count_o), 128'(0));
    chk("odd_mask01", 128'(out_lane_valid_o), 128'(2'b01));
    drain();

    // Flush with a simultaneous push.
    for (int n = 0; n < 4; n++) cycle(1'b1, 2'b11, 2'b00, 1'b0, 1'b0);
    idle_inputs(1'b0);
    chk("flush_pre_count", 128'(count_o), 128'(6));
    chk("flush_pre_valid", 128'(out_valid_o), 128'(1));
    cycle(1'b1, 2'b11, 2'b00, 1'b1, 1'b1);
    idle_inputs(1'b1);
    chk("flush_count", 128'(count_o), 128'(0));
    chk("flush_out_valid", 128'(out_valid_o), 128'(0));
    drain();

    // Asynchronous reset in the middle of traffic.
    cycle(1'b1, 2'b11, 2'b00, 1'b0, 1'b0);
    cycle(1'b1, 2'b11, 2'b00, 1'b0, 1'b0);
    cycle(1'b1, 2'b11, 2'b00, 1'b0, 1'b0);
    cycle(1'b1, 2'b01, 2'b00, 1'b0, 1'b0);
    idle_inputs(1'b0);
    chk("pre_rst_count", 128'(count_o), 128'(5));
    #1 rst = 1'b1;
    #1;
    chk("arst_count", 128'(count_o), 128'(0));
    chk("arst_out_valid", 128'(out_valid_o), 128'(0));
    chk("arst_in_ready", 128'(in_ready_o), 128'(1));
    chk("arst_lane_valid", 128'(out_lane_valid_o), 128'(0));
    chk("arst_out_data", out_data_o, 128'(0));
    m_fifo.delete(); m_stage.delete(); m_sv = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 2'b11, 2'b00, 1'b1, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
